// File: rtl/elm_hex_line_rx_pkg.sv
// elm_hex_line_rx_pkg
// Shared definitions for the ELM327 hex line receiver:
//   - ASCII constants for the characters with special meaning on the line
//   - fetch FSM state encoding
//   - character classification produced by ascii_hex_decode
package elm_hex_line_rx_pkg;

  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_PROMPT = 8'h3E;

  // IDLE waits for a character, TAKE consumes it, GAP1/GAP2 let the UART
  // pointer settle before the FIFO head is looked at again.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAKE,
    ST_GAP1,
    ST_GAP2
  } fetch_state_t;

  typedef enum logic [2:0] {
    CLS_HEX,
    CLS_IGNORE,
    CLS_EOL,
    CLS_PROMPT,
    CLS_ILLEGAL
  } char_class_t;

endpackage

// File: rtl/elm_hex_line_rx_ascii_hex_decode.sv
// ascii_hex_decode
// Purely combinational classifier for one ASCII character.
// Ports:
//   i_char     in   8  character to classify
//   o_is_hex   out  1  character is 0-9, A-F or a-f
//   o_nibble   out  4  nibble value when o_is_hex, else 0
//   o_class    out  3  char_class_t of the character
module ascii_hex_decode
  import elm_hex_line_rx_pkg::*;
(
  input  logic [7:0]  i_char,
  output logic        o_is_hex,
  output logic [3:0]  o_nibble,
  output char_class_t o_class
);

  logic w_isDigit;
  logic w_isLetter;

  assign w_isDigit  = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign w_isLetter = ((i_char >= 8'h41) && (i_char <= 8'h46)) ||
                      ((i_char >= 8'h61) && (i_char <= 8'h66));

  // Letters A-F and a-f both have low nibbles 1..6, so adding 9 gives
  // 10..15; digits already carry their value in the low nibble.
  always_comb begin
    o_is_hex = 1'b0;
    o_nibble = 4'h0;
    o_class  = CLS_ILLEGAL;
    if (w_isDigit) begin
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0];
      o_class  = CLS_HEX;
    end else if (w_isLetter) begin
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0] + 4'd9;
      o_class  = CLS_HEX;
    end else if ((i_char == CHAR_SPACE) || (i_char == CHAR_LF)) begin
      o_class = CLS_IGNORE;
    end else if (i_char == CHAR_CR) begin
      o_class = CLS_EOL;
    end else if (i_char == CHAR_PROMPT) begin
      o_class = CLS_PROMPT;
    end
  end

endmodule

// File: rtl/elm_hex_line_rx.sv
// elm_hex_line_rx
// Pulls ASCII characters from the UART rx FIFO and assembles ELM327 style
// hex lines ("41 0B 64\r") into a small byte buffer for the OBD decoder.
// Optional feature macro: ELM_HEXLINE_PROMPT_EN
//   defined   : '>' pulses prompt_tick and leaves the line alone
//   undefined : '>' counts as an illegal character, prompt_tick stays 0
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   rx_empty     UART FIFO empty
//   r_data       UART FIFO head character (bits [7:0] used)
//   rd_uart      one-cycle read strobe to the UART
//   line_valid   a complete line is held in the buffer
//   line_len     number of bytes in the held line
//   line_addr    buffer read address
//   line_byte    buffer byte at line_addr (combinational)
//   line_ack     consumer releases the buffer
//   e_char/e_odd/e_ovf  illegal char / unpaired nibble / overflow flags
//   prompt_tick  one-cycle pulse on '>' (macro builds only)
module elm_hex_line_rx
  import elm_hex_line_rx_pkg::*;
#(
  parameter int BUF_W = 4,
  parameter int DBIT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  output logic             line_valid,
  output logic [BUF_W:0]   line_len,
  input  logic [BUF_W-1:0] line_addr,
  output logic [7:0]       line_byte,
  input  logic             line_ack,
  output logic             e_char,
  output logic             e_odd,
  output logic             e_ovf,
  output logic             prompt_tick
);

  fetch_state_t r_state;
  logic [7:0]   r_buf [2**BUF_W];
  logic [BUF_W:0] r_wptr;
  logic [3:0]   r_hi;
  logic         r_half;
  logic         r_bad;
  logic         r_ovf;

  logic [7:0]   w_char;
  logic         w_isHex;
  logic [3:0]   w_nibble;
  char_class_t  w_class;
  logic         w_full;
  logic         w_wrEn;

  assign w_char = r_data[7:0];

  ascii_hex_decode u_decode (
    .i_char   (w_char),
    .o_is_hex (w_isHex),
    .o_nibble (w_nibble),
    .o_class  (w_class)
  );

  // The pointer never exceeds the depth, so its top bit alone means full.
  assign w_full = r_wptr[BUF_W];
  assign w_wrEn = (r_state == ST_TAKE) && w_isHex && r_half && !w_full;

  assign line_byte = r_buf[line_addr];

  // Byte buffer: the second nibble of a pair completes a byte and stores it
  // at the write pointer. Contents need no reset since line_len gates them.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_buf[r_wptr[BUF_W-1:0]] <= {r_hi, w_nibble};
    end
  end

  // Fetch FSM plus line assembly. rd_uart is raised on the IDLE->TAKE
  // transition so it is high exactly during TAKE, the cycle the head
  // character is consumed. The two gap states keep strobes at least four
  // clocks apart. Fetching stops while a line is held so the UART FIFO
  // buffers the backlog until the consumer acknowledges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      rd_uart     <= 1'b0;
      line_valid  <= 1'b0;
      line_len    <= '0;
      e_char      <= 1'b0;
      e_odd       <= 1'b0;
      e_ovf       <= 1'b0;
      prompt_tick <= 1'b0;
      r_wptr      <= '0;
      r_hi        <= 4'h0;
      r_half      <= 1'b0;
      r_bad       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      rd_uart     <= 1'b0;
      prompt_tick <= 1'b0;

      if (line_valid && line_ack) begin
        line_valid <= 1'b0;
        line_len   <= '0;
        e_char     <= 1'b0;
        e_odd      <= 1'b0;
        e_ovf      <= 1'b0;
        r_wptr     <= '0;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (!rx_empty && !line_valid) begin
            r_state <= ST_TAKE;
            rd_uart <= 1'b1;
          end
        end
        ST_TAKE: begin
          r_state <= ST_GAP1;
          unique case (w_class)
            CLS_HEX: begin
              if (!r_half) begin
                r_hi   <= w_nibble;
                r_half <= 1'b1;
              end else begin
                r_half <= 1'b0;
                if (w_full) begin
                  r_ovf <= 1'b1;
                end else begin
                  r_wptr <= r_wptr + 1'b1;
                end
              end
            end
            CLS_IGNORE: begin
            end
            CLS_EOL: begin
              // A bare CR with nothing collected and no errors is dropped.
              if ((r_wptr != '0) || r_half || r_bad || r_ovf) begin
                line_valid <= 1'b1;
                line_len   <= r_wptr;
                e_odd      <= r_half;
                e_char     <= r_bad;
                e_ovf      <= r_ovf;
              end
              r_wptr <= '0;
              r_half <= 1'b0;
              r_bad  <= 1'b0;
              r_ovf  <= 1'b0;
            end
            CLS_PROMPT: begin
`ifdef ELM_HEXLINE_PROMPT_EN
              prompt_tick <= 1'b1;
`else
              r_bad <= 1'b1;
`endif
            end
            default: begin
              r_bad <= 1'b1;
            end
          endcase
        end
        ST_GAP1: r_state <= ST_GAP2;
        ST_GAP2: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/elm_hex_line_rx.md
# elm_hex_line_rx

Consumes ASCII characters from the UART receive FIFO and assembles ELM327-style hex response lines (e.g. "41 0B 64\r") into a binary byte buffer. Sits directly downstream of the UART: drives its `rd_uart` strobe from `rx_empty`/`r_data`, and presents complete lines to the OBD decode logic through a valid/ack handshake.

## Interface
- `BUF_W`, 4: address bits of line byte buffer; depth = 2**BUF_W bytes.
- `DBIT`, 8: UART data width; only bits [7:0] used.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous active-high reset is fixed.
- `rx_empty`  in  1  UART rx FIFO empty.
- `r_data`  in  DBIT  UART rx FIFO head character.
- `rd_uart`  out  1  read strobe to UART; UART edge-detects it, so it is a one-cycle pulse.
- `line_valid`  out  1  complete line held in buffer.
- `line_len`  out  BUF_W+1  number of bytes in line (0..2**BUF_W).
- `line_addr`  in  BUF_W  read address into line buffer.
- `line_byte`  out  8  buffer byte at `line_addr`, combinational read.
- `line_ack`  in  1  consumer done; releases buffer.
- `e_char`  out  1  line contained an illegal character.
- `e_odd`  out  1  line ended with an unpaired nibble.
- `e_ovf`  out  1  line exceeded buffer depth.
- `prompt_tick`  out  1  one-cycle pulse on '>' (only with macro).

## Operation
- Fetch FSM states: IDLE, TAKE, GAP1, GAP2.
  - IDLE: if `rx_empty`=0 and not (`line_valid`=1), go TAKE.
  - TAKE: latch `r_data[7:0]`, assert `rd_uart` this cycle, process character, go GAP1.
  - GAP1 -> GAP2 -> IDLE unconditionally; gives the UART edge trigger and FIFO pointer two cycles to settle before `rx_empty`/`r_data` are resampled.
- Character classes: '0'-'9', 'A'-'F', 'a'-'f' = nibble; 0x20 space and 0x0A LF ignored; 0x0D CR = end of line; '>' (0x3E) = prompt; all else illegal.
- Nibble handling: first nibble held in `hi` with `half`=1; second nibble writes {hi,lo} to buffer at `wptr`, `wptr`++, `half`=0. Space between nibbles of a pair is ignored, not an error.
- Write when `wptr` = 2**BUF_W: byte dropped, sticky `ovf`=1.
- Illegal character: sticky `bad`=1, character otherwise ignored.
- CR with `wptr`=0, `half`=0, no error flags: empty line, discarded, no `line_valid`.
- CR otherwise: `line_valid`=1, `line_len`=`wptr`, `e_odd`=`half`, `e_char`=`bad`, `e_ovf`=`ovf`; working state cleared.
- While `line_valid`=1, no characters fetched; UART FIFO absorbs backlog.
- `line_ack` while `line_valid`=1: next cycle `line_valid`=0, `line_len`=0, all `e_*`=0, `wptr`=0. Ignored when `line_valid`=0.
- Reset mid-line discards partial line; reset while a UART read is pending loses at most one character.

## Timing
- Reset values: `rd_uart`=0, `line_valid`=0, `line_len`=0, `e_char`=`e_odd`=`e_ovf`=0, `prompt_tick`=0, FSM=IDLE, `wptr`=0, `half`=0.
- Throughput: one character per 4 clocks maximum.
- `line_valid` rises the cycle after TAKE of the CR.
- `prompt_tick` high the cycle after TAKE of '>'.
- `line_byte` valid in same cycle as `line_addr` (async read of register array).
- `line_ack` and CR arrival cannot coincide (fetch blocked while valid).

## Configuration
- `ELM_HEXLINE_PROMPT_EN` defined: '>' pulses `prompt_tick`, does not touch line state.
- Undefined: '>' is an illegal character (sets `bad`); `prompt_tick` tied 0.

## Structure
- Shared package: character constants (CR, LF, SPACE, PROMPT), FSM state enum, char-class enum.
- Sub-module `ascii_hex_decode`: combinational 8-bit char -> {is_hex, nibble[3:0], class}.

## Test plan
- Feed "41 0B 64\r" -> `line_valid`=1, `line_len`=3, bytes 0x41,0x0B,0x64, no errors; `line_ack` -> all cleared.
- Feed "7e8\r" -> `line_len`=1, byte 0x7E, `e_odd`=1.
- BUF_W=2, feed "0102030405\r" -> `line_len`=4, bytes 01..04, `e_ovf`=1.
- Feed "4Z1\r" -> `e_char`=1, `line_len`=1, byte 0x41.
- Feed "\r\n>" with macro -> no `line_valid`, one `prompt_tick`; without macro -> no pulse, next line reports `e_char`=1.
- Hold `line_ack`=0, queue "01\r02\r" -> second line not fetched until ack; `rd_uart` pulses exactly once per character, never within 3 cycles of previous pulse.
